// File: rtl/led_pkg.sv
// Shared rate-mode encoding for the LED rate tick generator.
// Mode index selects half-period = CLK_HZ >> mode.
package led_pkg;

    localparam int MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t RATE_0P5HZ = 2'd0;
    localparam mode_t RATE_1HZ   = 2'd1;
    localparam mode_t RATE_2HZ   = 2'd2;
    localparam mode_t RATE_4HZ   = 2'd3;

    // Wraps 4 Hz back to 0.5 Hz through natural 2-bit overflow.
    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 1'b1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer and debouncer with a one-cycle press pulse.
// A new level is accepted after DEBOUNCE_CYC consecutive differing samples.
module btn_debounce
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        // Any sample agreeing with the accepted level restarts the qualification.
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d    = '0;
            stable_d = sync2_q;
            press_d  = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/led_rate_tick_gen.sv
// Selectable-rate square clock and tick generator for the LED chaser.
// Define LED_RATE_TICK_PAUSE_EN to add the PAUSE freeze input.
module led_rate_tick_gen
    import led_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int RESET_MODE   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BTN,
`ifdef LED_RATE_TICK_PAUSE_EN
    input  logic              PAUSE,
`endif
    output logic              CLK_O,
    output logic              TICK,
    output logic [MODE_W-1:0] MODE
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    // HALF may equal 2**CW, so the terminal value is formed before narrowing.
    function automatic logic [CW-1:0] term_of(input mode_t m);
        int unsigned half;
        half = int'(CLK_HZ) >> m;
        return CW'(half - 1);
    endfunction

    logic          press;
    logic          run;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_q, clk_d;
    logic          tick_q, tick_d;
    mode_t         mode_q, mode_d;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .btn_i   (BTN),
        .press_o (press)
    );

`ifdef LED_RATE_TICK_PAUSE_EN
    assign run = ~PAUSE;
`else
    assign run = 1'b1;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        mode_d = mode_q;
        // A mode step outranks a coincident terminal count.
        if (press) begin
            mode_d = next_mode(mode_q);
            cnt_d  = '0;
            clk_d  = 1'b0;
        end else if (run) begin
            if (cnt_q == term_of(mode_q)) begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = ~clk_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            mode_q <= MODE_W'(RESET_MODE);
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            mode_q <= mode_d;
        end
    end

    assign CLK_O = clk_q;
    assign TICK  = tick_q;
    assign MODE  = mode_q;

endmodule

// File: tb/tb_led_rate_tick_gen.sv
// Directed bench for led_rate_tick_gen at CLK_HZ=16, DEBOUNCE_CYC=4.
// Expected waveforms derive from the half period and edges since restart.
module tb_led_rate_tick_gen;

    localparam int CLK_HZ       = 16;
    localparam int DEBOUNCE_CYC = 4;
    localparam int RESET_MODE   = 1;

    logic       CLK;
    logic       RST;
    logic       BTN;
`ifdef LED_RATE_TICK_PAUSE_EN
    logic       PAUSE;
`endif
    logic       CLK_O;
    logic       TICK;
    logic [1:0] MODE;

    int n_checks;
    int n_errors;

    led_rate_tick_gen #(
        .CLK_HZ       (CLK_HZ),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .RESET_MODE   (RESET_MODE)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .BTN   (BTN),
`ifdef LED_RATE_TICK_PAUSE_EN
        .PAUSE (PAUSE),
`endif
        .CLK_O (CLK_O),
        .TICK  (TICK),
        .MODE  (MODE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Edges k0+1..k1 after a divider restart; BTN follows pat bit by bit.
    task automatic watch(input int half, input int k0, input int k1,
                         input logic [63:0] pat, input logic [1:0] m);
        for (int k = k0 + 1; k <= k1; k++) begin
            BTN = pat[k-k0-1];
            step();
            check($sformatf("clk_o m%0d k%0d", m, k), CLK_O,
                  32'(((k / half) % 2) == 1));
            check($sformatf("tick m%0d k%0d", m, k), TICK,
                  32'((k % (2 * half)) == half));
        end
        check($sformatf("mode m%0d", m), MODE, m);
    endtask

    // Press lands on the 7th edge after BTN rises (2 sync + 4 debounce + 1).
    task automatic press_step(input logic [1:0] old_m, input logic [1:0] new_m);
        BTN = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("mode hold e%0d", i), MODE, old_m);
        end
        step();
        check("mode step", MODE, new_m);
        check("restart clk_o", CLK_O, 0);
        check("restart tick", TICK, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST = 1'b0;
        BTN = 1'b0;
`ifdef LED_RATE_TICK_PAUSE_EN
        PAUSE = 1'b0;
`endif
        step();
        check("rst clk_o", CLK_O, 0);
        check("rst tick", TICK, 0);
        check("rst mode", MODE, 1);
        step();
        RST = 1'b1;

        watch(8, 0, 48, 64'h0, 2'd1);

        press_step(2'd1, 2'd2);
        watch(4, 0, 16, 64'h7, 2'd2);

        press_step(2'd2, 2'd3);
        watch(2, 0, 12, 64'h1, 2'd3);

        press_step(2'd3, 2'd0);
        watch(16, 0, 40, 64'h1, 2'd0);

        press_step(2'd0, 2'd1);
        watch(8, 0, 20, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1);
        watch(8, 20, 40, 64'h0, 2'd1);

        watch(8, 40, 60, 64'hED, 2'd1);
        watch(8, 60, 65, 64'h0, 2'd1);

        // Event edge is k=72, a rising terminal count at half=8.
        press_step(2'd1, 2'd2);
        watch(4, 0, 8, 64'h1, 2'd2);

        press_step(2'd2, 2'd3);
        watch(2, 0, 3, 64'h1, 2'd3);
        check("mid-high clk_o", CLK_O, 1);
        RST = 1'b0;
        #1;
        check("async rst clk_o", CLK_O, 0);
        check("async rst tick", TICK, 0);
        check("async rst mode", MODE, 1);
        step();
        step();
        RST = 1'b1;
        watch(8, 0, 12, 64'h0, 2'd1);

`ifdef LED_RATE_TICK_PAUSE_EN
        PAUSE = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            check($sformatf("pause clk_o %0d", i), CLK_O, 1);
            check($sformatf("pause tick %0d", i), TICK, 0);
        end
        PAUSE = 1'b0;
`endif
        watch(8, 12, 40, 64'h0, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
